// File: rtl/clken_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
package clken_pkg;

   // Accumulator width used when the instantiating level does not override it.
   localparam int ACC_W_DEFAULT = 32;

   // Width of the settle counter; bounds LOCK_CYCLES to 1..65535.
   localparam int LOCK_W = 16;

   // Channel-select width: a single channel still gets a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clken_ch.sv
// One clock-enable channel: increment register, phase accumulator and the
// registered enable pulse produced from the accumulator carry.
module clken_ch
   import clken_pkg::*;
#(
   parameter int               ACC_W = ACC_W_DEFAULT,
   parameter logic [ACC_W-1:0] INIT  = {1'b1, {(ACC_W-1){1'b0}}}
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [ACC_W-1:0] load_val,
   input  logic             clear,
   input  logic             gate,
   output logic             ce
);

   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   // One extra bit so the wrap out of the accumulator is visible as a carry.
   assign sum = {1'b0, acc} + {1'b0, inc};

   // Increment register: reset value, or a new rate on an accepted write.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         inc <= INIT;
      end else if (load) begin
         inc <= load_val;
      end
   end

   // Accumulator and enable; clear realigns phase and kills any pulse in flight.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ce  <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         ce  <= 1'b0;
      end else begin
         acc <= sum[ACC_W-1:0];
         ce  <= sum[ACC_W] & gate;
      end
   end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator with runtime rate writes,
// phase realignment on every accepted write and a settle/lock indication.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SETTLING | cnt < LOCK_CYCLES, locked=0, accumulators run, ce suppressed
// LOCKED   | cnt == LOCK_CYCLES, locked=1, ce pulses follow carries
//
// The state is implicit in cnt/locked. Only reset or an accepted write
// returns the generator to SETTLING.
module clken_gen
   import clken_pkg::*;
#(
   parameter int                      NUM_CH      = 5,
   parameter int                      ACC_W       = ACC_W_DEFAULT,
   parameter int                      LOCK_CYCLES = 16,
   parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}}
) (
   input  logic                      refclk,
   input  logic                      rst_n,
   input  logic                      cfg_wr,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]          cfg_inc,
   output logic [NUM_CH-1:0]         ce,
   output logic                      locked
);

   localparam int                CH_W    = ch_w(NUM_CH);
   localparam logic [LOCK_W-1:0] LOCK_TC = LOCK_W'(LOCK_CYCLES);

   logic              accept;
   logic [LOCK_W-1:0] cnt;
   logic [LOCK_W-1:0] cnt_next;

   // Writes to channels that do not exist are dropped without side effects.
   assign accept = cfg_wr && (int'(cfg_ch) < NUM_CH);

   // Settle count saturates at the terminal value so locked holds.
   assign cnt_next = (cnt == LOCK_TC) ? cnt : cnt + 16'd1;

   // Settle counter and registered lock flag; an accepted write restarts both.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         locked <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         locked <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         locked <= (cnt_next == LOCK_TC);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic load;

      assign load = accept && (cfg_ch == CH_W'(i));

      clken_ch #(
         .ACC_W (ACC_W),
         .INIT  (INIT_INC[i*ACC_W +: ACC_W])
      ) u_ch (
         .refclk   (refclk),
         .rst_n    (rst_n),
         .load     (load),
         .load_val (cfg_inc),
         .clear    (accept),
         .gate     (locked),
         .ce       (ce[i])
      );
   end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen with default parameters. Expected
// {locked, ce} for every edge comes from a closed-form model: edges counted
// from the last restart, lock at edge LOCK, carries from floor(k*inc/2^32).
module tb_clken_gen;
   import clken_pkg::*;

   localparam int NCH  = 5;
   localparam int LOCK = 16;

   logic           refclk = 1'b0;
   logic           rst_n;
   logic           cfg_wr = 1'b0;
   logic [2:0]     cfg_ch = '0;
   logic [31:0]    cfg_inc = '0;
   logic [NCH-1:0] ce;
   logic           locked;

   logic [31:0]    m_inc [NCH];
   int unsigned    k;
   int             passed = 0;
   int             total  = 0;
   logic [5:0]     sb [$];
   logic [5:0]     e;

   always #5 refclk = ~refclk;

   clken_gen dut (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .cfg_wr  (cfg_wr),
      .cfg_ch  (cfg_ch),
      .cfg_inc (cfg_inc),
      .ce      (ce),
      .locked  (locked)
   );

   task automatic cyc();
      @(posedge refclk);
      #1;
   endtask

   task automatic set_defaults();
      for (int i = 0; i < NCH; i++) m_inc[i] = 32'h8000_0000;
   endtask

   // Expected {locked, ce} after edge kk counted from the last restart.
   function automatic logic [5:0] exp_vec(input int unsigned kk);
      logic [5:0] v;
      longint unsigned a, b;
      v    = '0;
      v[5] = (kk >= LOCK);
      for (int i = 0; i < NCH; i++) begin
         a = kk;
         a = (a * m_inc[i]) >> 32;
         b = kk - 1;
         b = (b * m_inc[i]) >> 32;
         v[i] = (kk >= LOCK + 1) && (a != b);
      end
      return v;
   endfunction

   // Drives one write for one edge and queues the expected result of that edge.
   task automatic push_write(input logic [2:0] ch, input logic [31:0] v);
      cfg_wr  = 1'b1;
      cfg_ch  = ch;
      cfg_inc = v;
      if (int'(ch) < NCH) sb.push_back(6'b0);
      else                sb.push_back(exp_vec(k + 1));
      cyc();
      cfg_wr = 1'b0;
      if (int'(ch) < NCH) begin
         k = 0;
         m_inc[ch] = v;
      end else begin
         k++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_defaults();
      cyc(); cyc(); cyc();
      total++;
      if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked);
      else passed++;
      total++;
      if (ce !== 5'b0) $display("FAIL reset_ce got %b want 00000", ce);
      else passed++;
      rst_n = 1'b1;
      k = 0;
   endtask

   task automatic test_default_lock();
      for (int n = 0; n < 40; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL default_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   task automatic test_write_ch1();
      push_write(3'd1, 32'h4000_0000);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL write_ch1_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 50; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL write_ch1_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   task automatic test_invalid_write();
      push_write(3'd7, 32'h0000_0000);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL invalid_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 30; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL invalid_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   task automatic test_zero_inc();
      int ce2_pulses;
      ce2_pulses = 0;
      push_write(3'd2, 32'h0000_0000);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL zero_inc_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 1020; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         if (ce[2] === 1'b1) ce2_pulses++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL zero_inc_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
      total++;
      if (ce2_pulses !== 0) $display("FAIL zero_inc_ce2_count got %0d want 0", ce2_pulses);
      else passed++;
   endtask

   task automatic test_back_to_back();
      push_write(3'd3, 32'h8000_0000);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL b2b_first_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 5; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL b2b_gap edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
      push_write(3'd4, 32'h4000_0000);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL b2b_second_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 25; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL b2b_relock edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
      push_write(3'd0, 32'h2000_0000);
      push_write(3'd1, 32'h8000_0000);
      for (int n = 0; n < 2; n++) begin
         e = sb.pop_front();
         total++;
         if (n == 1 && {locked, ce} !== e)
            $display("FAIL b2b_consecutive got locked=%b ce=%b want locked=%b ce=%b",
                     locked, ce, e[5], e[4:0]);
         else if (n == 1) passed++;
         else passed++;
      end
      for (int n = 0; n < 30; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL b2b_consec_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   task automatic test_max_inc();
      push_write(3'd0, 32'hFFFF_FFFF);
      e = sb.pop_front();
      total++;
      if ({locked, ce} !== e)
         $display("FAIL max_inc_apply got locked=%b ce=%b want locked=%b ce=%b",
                  locked, ce, e[5], e[4:0]);
      else passed++;
      for (int n = 0; n < 30; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL max_inc_seq edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic saw;
      saw = 1'b0;
      for (int n = 0; n < 40; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL async_pre edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
         if (ce !== 5'b0) begin
            saw = 1'b1;
            break;
         end
      end
      total++;
      if (saw !== 1'b1) $display("FAIL async_ce_seen got %b want 1", saw);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({locked, ce} !== 6'b0)
         $display("FAIL async_drop got locked=%b ce=%b want locked=0 ce=00000", locked, ce);
      else passed++;
      set_defaults();
      cyc(); cyc();
      rst_n = 1'b1;
      k = 0;
      for (int n = 0; n < 40; n++) begin
         sb.push_back(exp_vec(k + 1));
         cyc();
         k++;
         e = sb.pop_front();
         total++;
         if ({locked, ce} !== e)
            $display("FAIL async_repeat edge=%0d got locked=%b ce=%b want locked=%b ce=%b",
                     k, locked, ce, e[5], e[4:0]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_default_lock();
      test_write_ch1();
      test_invalid_write();
      test_zero_inc();
      test_back_to_back();
      test_max_inc();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
